pc_gen: RTL

Fetch-stage program counter generator with a direct-mapped branch history table. It sits directly upstream of the IF/ID pipeline register. Each cycle it supplies the fetch PC, the fetch-enable, and the branch prediction (taken, 2-bit state, target) that travel with the instruction into decode. Its next-PC selection handles exception flush, execute-stage mispredict redirect, stall, and a predicted-taken branch. A predicted redirect takes effect only after the MIPS delay slot.

---
 rtl/pc_gen_pkg.sv | 54 +++++
 rtl/pc_gen_bht.sv | 84 ++++++++
 rtl/pc_gen.sv | 113 +++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch-stage PC generator and its BHT.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: stall_t pipeline stall vector, bht_entry_t, counter encodings,
// pc_gen FSM states, default reset PC and BHT size, and the BHT helpers.
package pc_gen_pkg;

   localparam logic [31:0] RESET_PC_DEF  = 32'hbfc0_0000;
   localparam int          BHT_IDX_W_DEF = 6;

   // 2-bit saturating counter encodings
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   // Per-stage stall vector shared by the whole pipeline
   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic stall_ex;
      logic stall_mem;
      logic stall_wb;
   } stall_t;

   // Tag is held zero-extended to 30 bits (pc[31:2] >> idx_w) so the entry
   // layout does not depend on the table size.
   typedef struct packed {
      logic        valid;
      logic [29:0] tag;
      logic [31:0] target;
      logic [1:0]  cnt;
   } bht_entry_t;

   typedef enum logic {
      SEQ   = 1'b0,
      DSLOT = 1'b1
   } pc_state_t;

   function automatic logic [29:0] bht_tag(input logic [29:0] pc_word, input int idx_w);
      return pc_word >> idx_w;
   endfunction

   function automatic logic [1:0] sat_cnt(input logic [1:0] cnt, input logic taken);
      logic [1:0] res;
      res = cnt;
      if (taken && cnt != ST)
         res = cnt + 2'b01;
      else if (!taken && cnt != SNT)
         res = cnt - 2'b01;
      return res;
   endfunction

endpackage

// File: rtl/pc_gen_bht.sv
// Direct-mapped branch history table: combinational lookup, clocked update.
// Latency: lookup 0 cycles; update visible the cycle after upd_valid.
// Backpressure: none; an update is accepted every cycle it is offered.
// Ports: clk, rst (async active-low); rd_pc -> rd_taken/rd_state/rd_target;
// upd_valid/upd_pc/upd_taken/upd_target write the resolved outcome.
module bht
   import pc_gen_pkg::*;
#(
   parameter int BHT_IDX_W = BHT_IDX_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rd_pc,
   output logic        rd_taken,
   output logic [1:0]  rd_state,
   output logic [31:0] rd_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target
);

   localparam int ENTRIES = 1 << BHT_IDX_W;

   bht_entry_t             tbl [ENTRIES];
   logic [BHT_IDX_W-1:0]   rd_idx, up_idx;
   bht_entry_t             rd_e, up_e, up_new;
   logic                   rd_hit, up_hit, up_we;

   // Word-aligned fetch: byte-offset bits carry no information here
   logic unused_lsb;
   assign unused_lsb = ^{rd_pc[1:0], upd_pc[1:0]};

   assign rd_idx = rd_pc[BHT_IDX_W+1:2];
   assign up_idx = upd_pc[BHT_IDX_W+1:2];
   assign rd_e   = tbl[rd_idx];
   assign up_e   = tbl[up_idx];
   assign rd_hit = rd_e.valid && (rd_e.tag == bht_tag(rd_pc[31:2], BHT_IDX_W));
   assign up_hit = up_e.valid && (up_e.tag == bht_tag(upd_pc[31:2], BHT_IDX_W));

   // Lookup reads the table register directly, so a same-cycle update to the
   // same index is only seen on the following cycle.
   always_comb begin
      rd_taken  = 1'b0;
      rd_state  = WNT;
      rd_target = 32'h0;
      if (rd_hit) begin
         rd_taken  = rd_e.cnt[1];
         rd_state  = rd_e.cnt;
         rd_target = rd_e.target;
      end
   end

   // Not-taken misses leave the table alone: no point spending an entry on a
   // branch that would predict fall-through anyway.
   always_comb begin
      up_new = up_e;
      up_we  = 1'b0;
      if (upd_valid) begin
         if (up_hit) begin
            up_we      = 1'b1;
            up_new.cnt = sat_cnt(up_e.cnt, upd_taken);
            if (upd_taken)
               up_new.target = upd_target;
         end else if (upd_taken) begin
            up_we         = 1'b1;
            up_new.valid  = 1'b1;
            up_new.tag    = bht_tag(upd_pc[31:2], BHT_IDX_W);
            up_new.target = upd_target;
            up_new.cnt    = WT;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < ENTRIES; i++)
            tbl[i] <= '0;
      end else if (up_we) begin
         tbl[up_idx] <= up_new;
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Fetch-stage PC generator with optional BHT prediction and delay-slot redirect.
// Latency: next PC registered one cycle after flush/branch_flag/prediction.
// Backpressure: stall.stall_if freezes pc, FSM and the redirect register.
// Ports: clk, rst (async active-low); stall, flush/flush_pc, branch_flag/
// branch_target, upd_* (BHT training); pc, pc_ce, pred_taken/state/target.
// Build option: define BRANCH_PREDICT_EN to build the BHT and DSLOT redirect.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
   parameter int          BHT_IDX_W = BHT_IDX_W_DEF
) (
   input  logic        clk,
   input  logic        rst,
   input  stall_t      stall,
   input  logic        flush,
   input  logic [31:0] flush_pc,
   input  logic        branch_flag,
   input  logic [31:0] branch_target,
   input  logic        upd_valid,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   output logic [31:0] pc,
   output logic        pc_ce,
   output logic        pred_taken,
   output logic [1:0]  pred_state,
   output logic [31:0] pred_target
);

   pc_state_t   state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] redir_q, redir_d;
   logic        ce_q;
   logic        lk_taken;
   logic [1:0]  lk_state;
   logic [31:0] lk_target;

   logic unused_stall;
   assign unused_stall = ^{stall.stall_id, stall.stall_ex, stall.stall_mem, stall.stall_wb};

`ifdef BRANCH_PREDICT_EN
   bht #(.BHT_IDX_W(BHT_IDX_W)) u_bht (
      .clk        (clk),
      .rst        (rst),
      .rd_pc      (pc_q),
      .rd_taken   (lk_taken),
      .rd_state   (lk_state),
      .rd_target  (lk_target),
      .upd_valid  (upd_valid),
      .upd_pc     (upd_pc),
      .upd_taken  (upd_taken),
      .upd_target (upd_target)
   );
`else
   assign lk_taken  = 1'b0;
   assign lk_state  = SNT;
   assign lk_target = 32'h0;

   logic unused_upd;
   assign unused_upd = ^{upd_valid, upd_pc, upd_taken, upd_target};
`endif

   assign pc          = pc_q;
   assign pc_ce       = ce_q;
   assign pred_taken  = ce_q & lk_taken;
   assign pred_state  = ce_q ? lk_state  : 2'b00;
   assign pred_target = ce_q ? lk_target : 32'h0;

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      redir_d = redir_q;
      if (!ce_q) begin
         // First edge after reset only raises pc_ce so RESET_PC is fetched
      end else if (flush) begin
         pc_d    = flush_pc;
         state_d = SEQ;
      end else if (branch_flag) begin
         pc_d    = branch_target;
         state_d = SEQ;
      end else if (stall.stall_if) begin
         // hold everything
      end else if (state_q == DSLOT) begin
         // Delay slot issued; a prediction on the slot itself is ignored
         pc_d    = redir_q;
         state_d = SEQ;
`ifdef BRANCH_PREDICT_EN
      end else if (lk_taken) begin
         pc_d    = pc_q + 32'd4;
         redir_d = lk_target;
         state_d = DSLOT;
`endif
      end else begin
         pc_d = pc_q + 32'd4;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q    <= RESET_PC;
         ce_q    <= 1'b0;
         state_q <= SEQ;
         redir_q <= 32'h0;
      end else begin
         pc_q    <= pc_d;
         ce_q    <= 1'b1;
         state_q <= state_d;
         redir_q <= redir_d;
      end
   end

endmodule
